// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one RAM16K between a CPU port (0) and a DMA/refresh port (1).
// Optional RAM_ARB_LOCK_EN adds lock_0/lock_1 so a requester can keep the RAM for read-modify-write.
module ram_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_0,
    input  logic        req_1,
    input  logic        we_0,
    input  logic        we_1,
    input  logic [13:0] addr_0,
    input  logic [13:0] addr_1,
    input  logic [15:0] wdata_0,
    input  logic [15:0] wdata_1,
`ifdef RAM_ARB_LOCK_EN
    input  logic        lock_0,
    input  logic        lock_1,
`endif
    output logic        ack_0,
    output logic        ack_1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        ram_load,
    output logic [13:0] ram_address,
    output logic [15:0] ram_data_in,
    input  logic [15:0] ram_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       win;
`ifdef RAM_ARB_LOCK_EN
    logic       lock_hold;
`endif

    // A lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        win = req_1;
        if (req_0 && req_1)
            win = ~last_grant;
`ifdef RAM_ARB_LOCK_EN
        if (lock_hold && (last_grant ? req_1 : req_0))
            win = last_grant;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            ack_0       <= 1'b0;
            ack_1       <= 1'b0;
            busy        <= 1'b0;
            ram_load    <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
            rdata       <= '0;
`ifdef RAM_ARB_LOCK_EN
            lock_hold   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef RAM_ARB_LOCK_EN
                    // Any grant consumes the hold; an absent holder forfeits it.
                    lock_hold <= 1'b0;
`endif
                    if (req_0 || req_1) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        last_grant  <= win;
                        ram_address <= win ? addr_1  : addr_0;
                        ram_data_in <= win ? wdata_1 : wdata_0;
                        ram_load    <= win ? we_1    : we_0;
                    end
                end
                ACCESS: begin
                    // ram_out is sampled on the same edge the RAM commits, so a write returns old data.
                    rdata    <= ram_out;
                    ram_load <= 1'b0;
                    ack_0    <= ~last_grant;
                    ack_1    <= last_grant;
                    state    <= DONE;
`ifdef RAM_ARB_LOCK_EN
                    lock_hold <= last_grant ? lock_1 : lock_0;
`endif
                end
                DONE: begin
                    ack_0 <= 1'b0;
                    ack_1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM16K (combinational read, clocked write).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_0, req_1, we_0, we_1;
    logic [13:0] addr_0, addr_1;
    logic [15:0] wdata_0, wdata_1;
    logic        ack_0, ack_1, busy, ram_load;
    logic [15:0] rdata, ram_data_in, ram_out;
    logic [13:0] ram_address;
`ifdef RAM_ARB_LOCK_EN
    logic        lock_0, lock_1;
`endif

    logic [15:0] mem [0:16383];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_data_in;
    assign ram_out = mem[ram_address];

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
`ifdef RAM_ARB_LOCK_EN
        .lock_0(lock_0), .lock_1(lock_1),
`endif
        .ack_0(ack_0), .ack_1(ack_1), .rdata(rdata), .busy(busy),
        .ram_load(ram_load), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_out(ram_out)
    );

    // Single-port transaction driver; lat = negedges from drive to ack (99 on timeout).
    task automatic access(input int port, input logic we, input logic [13:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clk);
        if (port == 0) begin req_0 = 1; we_0 = we; addr_0 = addr; wdata_0 = wd; end
        else           begin req_1 = 1; we_1 = we; addr_1 = addr; wdata_1 = wd; end
        lat = 99;
        rd  = 16'h0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((port == 0 && ack_0) || (port == 1 && ack_1)) begin
                lat = i;
                rd  = rdata;
                break;
            end
        end
        if (port == 0) req_0 = 0; else req_1 = 0;
    endtask

    task automatic test_reset;
        reset_n = 0;
        req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
        addr_0 = 0; addr_1 = 0; wdata_0 = 0; wdata_1 = 0;
`ifdef RAM_ARB_LOCK_EN
        lock_0 = 0; lock_1 = 0;
`endif
        #12;
        checks++;
        if ({ack_0, ack_1, busy, ram_load} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl got %b exp 0000", {ack_0, ack_1, busy, ram_load});
        end
        checks++;
        if ({ram_address, ram_data_in, rdata} !== 46'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h exp 0", ram_address, ram_data_in, rdata);
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_write_read;
        logic [15:0] rd;
        int lat;
        @(negedge clk);
        req_0 = 1; we_0 = 1; addr_0 = 14'h1234; wdata_0 = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({ram_load, busy, ack_0} !== 3'b110 || ram_address !== 14'h1234 || ram_data_in !== 16'hBEEF) begin
            errors++; $display("FAIL wr_access got ld%b busy%b ack%b %h %h exp 110 1234 beef",
                               ram_load, busy, ack_0, ram_address, ram_data_in);
        end
        @(negedge clk);
        checks++;
        if ({ack_0, ack_1, ram_load} !== 3'b100) begin
            errors++; $display("FAIL wr_ack got %b exp 100", {ack_0, ack_1, ram_load});
        end
        req_0 = 0;
        @(negedge clk);
        checks++;
        if ({ack_0, busy, ram_load} !== 3'b000) begin
            errors++; $display("FAIL wr_idle got %b exp 000", {ack_0, busy, ram_load});
        end
        access(1, 0, 14'h1234, 16'h0, rd, lat);
        checks++;
        if (rd !== 16'hBEEF || lat !== 2) begin
            errors++; $display("FAIL rd_1234 got %h lat %0d exp beef lat 2", rd, lat);
        end
    endtask

    task automatic test_round_robin;
        logic [5:0] seq = '0;
        int n = 0, last_cyc = 0;
        logic overlap = 0;
        @(negedge clk);
        req_0 = 1; req_1 = 1; we_0 = 0; we_1 = 0; addr_0 = 14'h1234; addr_1 = 14'h1234;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack_0 && ack_1) overlap = 1;
            if (ack_0 || ack_1) begin
                seq[n] = ack_1;
                n++;
                last_cyc = c;
                if (n == 6) begin req_0 = 0; req_1 = 0; break; end
            end
        end
        req_0 = 0; req_1 = 0;
        checks++;
        if (n !== 6 || seq !== 6'b101010) begin
            errors++; $display("FAIL rr_order got n%0d seq %b exp n6 seq 101010 (lsb first)", n, seq);
        end
        checks++;
        if (overlap !== 1'b0) begin
            errors++; $display("FAIL rr_overlap got %b exp 0", overlap);
        end
        checks++;
        if (last_cyc !== 17) begin
            errors++; $display("FAIL rr_rate got %0d exp 17", last_cyc);
        end
    endtask

    task automatic test_addr_wrap;
        logic [15:0] rd;
        int lat;
        access(0, 1, 14'h0000, 16'hA5A5, rd, lat);
        access(1, 1, 14'h3FFF, 16'h0001, rd, lat);
        access(1, 0, 14'h3FFF, 16'h0000, rd, lat);
        checks++;
        if (rd !== 16'h0001) begin
            errors++; $display("FAIL rd_3fff got %h exp 0001", rd);
        end
        access(0, 0, 14'h0000, 16'h0000, rd, lat);
        checks++;
        if (rd !== 16'hA5A5) begin
            errors++; $display("FAIL rd_0000 got %h exp a5a5", rd);
        end
    endtask

    task automatic test_reset_mid_access;
        logic [15:0] rd;
        int lat;
        logic seen_ack = 0;
        access(0, 1, 14'h0042, 16'h5555, rd, lat);
        @(negedge clk);
        req_0 = 1; we_0 = 1; addr_0 = 14'h0042; wdata_0 = 16'hAAAA;
        @(negedge clk);
        checks++;
        if (ram_load !== 1'b1) begin
            errors++; $display("FAIL rst_pre_load got %b exp 1", ram_load);
        end
        #2 reset_n = 0;
        #1;
        checks++;
        if ({busy, ram_load, ack_0, rdata} !== 19'h0) begin
            errors++; $display("FAIL rst_async got busy%b ld%b ack%b rd %h exp 0", busy, ram_load, ack_0, rdata);
        end
        req_0 = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack_0 || ack_1) seen_ack = 1;
        end
        reset_n = 1;
        @(negedge clk);
        if (ack_0 || ack_1) seen_ack = 1;
        checks++;
        if (seen_ack !== 1'b0) begin
            errors++; $display("FAIL rst_no_ack got %b exp 0", seen_ack);
        end
        access(0, 0, 14'h0042, 16'h0, rd, lat);
        checks++;
        if (rd !== 16'h5555 || lat !== 2) begin
            errors++; $display("FAIL rst_reread got %h lat %0d exp 5555 lat 2", rd, lat);
        end
    endtask

    task automatic test_rdata_hold;
        logic [15:0] rd;
        int lat;
        access(1, 1, 14'h0200, 16'h7E7E, rd, lat);
        @(negedge clk);
        req_0 = 1; we_0 = 0; addr_0 = 14'h0200;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_0 !== 1'b1 || rdata !== 16'h7E7E) begin
            errors++; $display("FAIL hold_ack got ack%b %h exp ack1 7e7e", ack_0, rdata);
        end
        req_0 = 0;
        @(negedge clk);
        checks++;
        if ({ack_0, busy} !== 2'b00 || rdata !== 16'h7E7E) begin
            errors++; $display("FAIL hold_idle got ack%b busy%b %h exp 00 7e7e", ack_0, busy, rdata);
        end
    endtask

`ifdef RAM_ARB_LOCK_EN
    task automatic test_lock;
        logic [2:0] seq = '0;
        int n = 0;
        @(negedge clk);
        req_0 = 1; we_0 = 0; addr_0 = 14'h0100; lock_0 = 1;
        @(negedge clk);
        req_1 = 1; we_1 = 0; addr_1 = 14'h0100;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (ack_0 || ack_1) begin
                seq[n] = ack_1;
                n++;
                if (ack_1) req_1 = 0;
                else if (n == 1) begin we_0 = 1; wdata_0 = 16'h1357; lock_0 = 0; end
                else req_0 = 0;
            end
        end
        req_0 = 0; req_1 = 0; lock_0 = 0;
        checks++;
        if (n !== 3 || seq !== 3'b100) begin
            errors++; $display("FAIL lock_order got n%0d seq %b exp n3 seq 100 (lsb first)", n, seq);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_write_read;
        test_round_robin;
        test_addr_wrap;
        test_reset_mid_access;
        test_rdata_hold;
`ifdef RAM_ARB_LOCK_EN
        test_lock;
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
